// File: rtl/asic_readout_sequencer.sv
// Readout sequencer for a daisy-chained ASIC string: frames each chip-chain readout
// with header/trailer/status words and shares the FIFO write port with the deserialiser.
module asic_readout_sequencer #(
  parameter int                       ASIC_NUM       = 4,
  parameter int                       START_CYCLES   = 4,
  parameter int                       TIMEOUT_WIDTH  = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 20'd800000,
  parameter logic [15:0]              HEADER_WORD    = 16'hA5A5,
  parameter logic [15:0]              TRAILER_WORD   = 16'h5A5A
) (
  input  logic        ReadClk,
  input  logic        reset_n,
  input  logic        ReadoutRequest,
  input  logic        TransmitOn,
  input  logic        EndReadout,
  input  logic [15:0] DeserData,
  input  logic        DeserWriteEn,
  input  logic        FifoFull,
  output logic        StartReadout,
  output logic [15:0] FifoData,
  output logic        FifoWriteEn,
  output logic        ReadoutBusy,
  output logic        ReadoutDone,
  output logic [3:0]  ChipCount,
  output logic        TimeoutError
);

  localparam int START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, HEADER, START, WAIT_CHIP, RECEIVE, CHECK, TRAILER, STATUS, DONE
  } stateT;

  stateT state, nextState;

  logic                     transmitOnP1, transmitOnP2, transmitOnP3;
  logic                     endReadoutP1, endReadoutP2, endReadoutP3;
  logic                     requestP1, requestP2, requestP3;
  logic [START_W-1:0]       startCnt;
  logic [TIMEOUT_WIDTH-1:0] timeoutCnt;
  logic                     reqEdge, syncChange, timeoutHit, timeoutAbort;
  logic                     markerOk, markerWrite;
  logic [15:0]              markerWord;

  // Input synchronisers; the third stage feeds edge and change detection
  always_ff @(posedge ReadClk or negedge reset_n) begin
    if (!reset_n) begin
      transmitOnP1 <= 1'b1;
      transmitOnP2 <= 1'b1;
      transmitOnP3 <= 1'b1;
      endReadoutP1 <= 1'b0;
      endReadoutP2 <= 1'b0;
      endReadoutP3 <= 1'b0;
      requestP1    <= 1'b0;
      requestP2    <= 1'b0;
      requestP3    <= 1'b0;
    end else begin
      transmitOnP1 <= TransmitOn;
      transmitOnP2 <= transmitOnP1;
      transmitOnP3 <= transmitOnP2;
      endReadoutP1 <= EndReadout;
      endReadoutP2 <= endReadoutP1;
      endReadoutP3 <= endReadoutP2;
      requestP1    <= ReadoutRequest;
      requestP2    <= requestP1;
      requestP3    <= requestP2;
    end
  end

  assign reqEdge    = requestP2 & ~requestP3;
  assign syncChange = (transmitOnP2 != transmitOnP3) | (endReadoutP2 != endReadoutP3);
  assign timeoutHit = (timeoutCnt == TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1)) & ~syncChange;
  assign markerOk   = ~FifoFull & ~DeserWriteEn;

  always_ff @(posedge ReadClk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState    = state;
    timeoutAbort = 1'b0;
    case (state)
      IDLE:      if (reqEdge) nextState = HEADER;
      HEADER:    if (markerOk) nextState = START;
      START:     if (startCnt == START_W'(START_CYCLES - 1)) nextState = WAIT_CHIP;
      WAIT_CHIP: begin
        // EndReadout takes priority over a coincident TransmitOn fall
        if (endReadoutP2)       nextState = TRAILER;
        else if (!transmitOnP2) nextState = RECEIVE;
        else if (timeoutHit) begin
          nextState    = TRAILER;
          timeoutAbort = 1'b1;
        end
      end
      RECEIVE: begin
        if (transmitOnP2) nextState = CHECK;
        else if (timeoutHit) begin
          nextState    = TRAILER;
          timeoutAbort = 1'b1;
        end
      end
      CHECK:     nextState = (ChipCount == 4'(ASIC_NUM)) ? TRAILER : WAIT_CHIP;
      TRAILER:   if (markerOk) nextState = STATUS;
      STATUS:    if (markerOk) nextState = DONE;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge ReadClk or negedge reset_n) begin
    if (!reset_n) begin
      startCnt     <= '0;
      timeoutCnt   <= '0;
      ChipCount    <= '0;
      TimeoutError <= 1'b0;
      ReadoutBusy  <= 1'b0;
    end else begin
      startCnt <= (state == START) ? startCnt + 1'b1 : '0;
      if (((state == WAIT_CHIP) || (state == RECEIVE)) && !syncChange)
        timeoutCnt <= timeoutCnt + 1'b1;
      else
        timeoutCnt <= '0;
      if (state == IDLE && reqEdge) begin
        ChipCount    <= '0;
        TimeoutError <= 1'b0;
        ReadoutBusy  <= 1'b1;
      end
      if (state == RECEIVE && transmitOnP2 && ChipCount != 4'hF)
        ChipCount <= ChipCount + 1'b1;
      if (timeoutAbort) TimeoutError <= 1'b1;
      if (state == DONE) ReadoutBusy <= 1'b0;
    end
  end

  // Deserialiser writes always pass straight through; markers only fill idle FIFO slots
  always_comb begin
    StartReadout = (state == START);
    ReadoutDone  = (state == DONE);
    markerWrite  = 1'b0;
    markerWord   = 16'h0000;
    case (state)
      HEADER:  begin markerWrite = markerOk; markerWord = HEADER_WORD;  end
      TRAILER: begin markerWrite = markerOk; markerWord = TRAILER_WORD; end
      STATUS:  begin
        markerWrite = markerOk;
        markerWord  = {TimeoutError, 3'b000, ChipCount, 8'h00};
      end
      default: ;
    endcase
    FifoWriteEn = DeserWriteEn | markerWrite;
    if (DeserWriteEn)     FifoData = DeserData;
    else if (markerWrite) FifoData = markerWord;
    else                  FifoData = 16'h0000;
  end

endmodule

// File: tb/tb_asic_readout_sequencer.sv
// Scoreboard bench for asic_readout_sequencer: stimulus pushes expected FIFO words,
// a negedge monitor pops and compares every FIFO write.
module tb_asic_readout_sequencer;

  localparam int          ASIC_NUM     = 4;
  localparam int          START_CYCLES = 4;
  localparam logic [15:0] HDR          = 16'hA5A5;
  localparam logic [15:0] TRL          = 16'h5A5A;

  logic        ReadClk = 1'b0;
  logic        reset_n, ReadoutRequest, TransmitOn, EndReadout, DeserWriteEn, FifoFull;
  logic [15:0] DeserData;
  logic        StartReadout, FifoWriteEn, ReadoutBusy, ReadoutDone, TimeoutError;
  logic [15:0] FifoData;
  logic [3:0]  ChipCount;

  asic_readout_sequencer #(
    .ASIC_NUM(ASIC_NUM), .START_CYCLES(START_CYCLES), .TIMEOUT_WIDTH(20),
    .TIMEOUT_CYCLES(20'd100), .HEADER_WORD(HDR), .TRAILER_WORD(TRL)
  ) dut (
    .ReadClk(ReadClk), .reset_n(reset_n), .ReadoutRequest(ReadoutRequest),
    .TransmitOn(TransmitOn), .EndReadout(EndReadout), .DeserData(DeserData),
    .DeserWriteEn(DeserWriteEn), .FifoFull(FifoFull), .StartReadout(StartReadout),
    .FifoData(FifoData), .FifoWriteEn(FifoWriteEn), .ReadoutBusy(ReadoutBusy),
    .ReadoutDone(ReadoutDone), .ChipCount(ChipCount), .TimeoutError(TimeoutError)
  );

  always #5 ReadClk = ~ReadClk;

  int          cyc = 0;
  int          nChecks = 0, nFail = 0, doneCount = 0;
  int          hdrCyc = -1, reqCyc = 0, startEnd = 0;
  logic [15:0] expQ[$];
  logic [15:0] expWord;

  always @(posedge ReadClk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: status word is built from the frame's chip total and timeout flag
  function automatic logic [15:0] statusWord(input int chips, input bit to);
    int c;
    c = (chips > ASIC_NUM) ? ASIC_NUM : chips;
    c = (c > 15) ? 15 : c;
    return {to, 3'b000, c[3:0], 8'h00};
  endfunction

  always @(negedge ReadClk) begin
    if (ReadoutDone) doneCount++;
    if (reset_n && FifoFull) chk("full_block", FifoWriteEn, DeserWriteEn);
    if (FifoWriteEn) begin
      if (!DeserWriteEn && FifoData == HDR) hdrCyc = cyc;
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", FifoData, cyc);
      end else begin
        expWord = expQ.pop_front();
        chk("fifo_word", FifoData, expWord);
      end
    end
  end

  task automatic tick();
    @(posedge ReadClk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic requestFrame();
    ReadoutRequest = 1'b1;
    reqCyc = cyc;
    expQ.push_back(HDR);
  endtask

  task automatic waitStart();
    int n, w;
    n = 0;
    while (!StartReadout && n < 200) begin tick(); n++; end
    chk("start_seen", StartReadout, 1'b1);
    w = 0;
    while (StartReadout && w < 50) begin tick(); w++; end
    chk("start_width", w, START_CYCLES);
    startEnd = cyc;
  endtask

  task automatic chipWindow(input bit last, input int chipsExp, input bit to);
    TransmitOn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      DeserWriteEn = ($urandom_range(0, 3) == 0);
      DeserData    = 16'($urandom);
      if (DeserWriteEn) expQ.push_back(DeserData);
      tick();
    end
    DeserWriteEn = 1'b0;
    TransmitOn   = 1'b1;
    if (last) begin
      expQ.push_back(TRL);
      expQ.push_back(statusWord(chipsExp, to));
    end else begin
      waitCycles($urandom_range(4, 10));
    end
  endtask

  task automatic endFrame(input int snap, input int chipsExp, input bit to);
    int n;
    n = 0;
    while (doneCount == snap && n < 400) begin tick(); n++; end
    chk("done_seen", (doneCount > snap), 1'b1);
    waitCycles(3);
    chk("done_pulses", doneCount - snap, 1);
    chk("chip_count", ChipCount, chipsExp);
    chk("timeout_err", TimeoutError, to);
    chk("busy_after", ReadoutBusy, 1'b0);
    chk("queue_drained", expQ.size(), 0);
  endtask

  task automatic runFrame(input int nWin);
    int snap;
    snap = doneCount;
    requestFrame();
    waitStart();
    chk("busy_in_frame", ReadoutBusy, 1'b1);
    for (int i = 0; i < nWin; i++)
      chipWindow((nWin >= ASIC_NUM) && (i == ASIC_NUM - 1), nWin, 1'b0);
    if (nWin < ASIC_NUM) begin
      expQ.push_back(TRL);
      expQ.push_back(statusWord(nWin, 1'b0));
      EndReadout = 1'b1;
    end
    endFrame(snap, (nWin > ASIC_NUM) ? ASIC_NUM : nWin, 1'b0);
    EndReadout     = 1'b0;
    ReadoutRequest = 1'b0;
    waitCycles(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, n;
    reset_n = 1'b0; ReadoutRequest = 1'b0; TransmitOn = 1'b1; EndReadout = 1'b0;
    DeserWriteEn = 1'b0; DeserData = 16'h0000; FifoFull = 1'b0;
    waitCycles(3);
    chk("rst_start", StartReadout, 1'b0);
    chk("rst_wen", FifoWriteEn, 1'b0);
    chk("rst_data", FifoData, 16'h0000);
    chk("rst_busy", ReadoutBusy, 1'b0);
    chk("rst_done", ReadoutDone, 1'b0);
    chk("rst_chips", ChipCount, 4'd0);
    chk("rst_timeout", TimeoutError, 1'b0);
    reset_n = 1'b1;
    waitCycles(2);

    // Full frame of ASIC_NUM chips, with header latency
    runFrame(ASIC_NUM);
    chk("header_latency", hdrCyc - reqCyc, 3);

    // EndReadout after two chips, then random frame lengths
    runFrame(2);
    repeat (3) runFrame($urandom_range(1, ASIC_NUM));

    // Timeout: chain never transmits
    snap = doneCount;
    requestFrame();
    waitStart();
    expQ.push_back(TRL);
    expQ.push_back(statusWord(0, 1'b1));
    n = 0;
    while (!TimeoutError && n < 300) begin tick(); n++; end
    chk("timeout_timing", ((cyc - startEnd) >= 98) && ((cyc - startEnd) <= 102), 1'b1);
    endFrame(snap, 0, 1'b1);
    ReadoutRequest = 1'b0;
    waitCycles(4);

    // FIFO full during header, deserialiser collision during trailer
    snap = doneCount;
    FifoFull = 1'b1;
    requestFrame();
    waitCycles(13);
    chk("busy_while_full", ReadoutBusy, 1'b1);
    FifoFull = 1'b0;
    waitStart();
    chipWindow(1'b0, 1, 1'b0);
    FifoFull   = 1'b1;
    EndReadout = 1'b1;
    waitCycles(8);
    FifoFull = 1'b0;
    for (int i = 0; i < 2; i++) begin
      DeserWriteEn = 1'b1;
      DeserData    = 16'($urandom);
      expQ.push_back(DeserData);
      tick();
    end
    DeserWriteEn = 1'b0;
    expQ.push_back(TRL);
    expQ.push_back(statusWord(1, 1'b0));
    endFrame(snap, 1, 1'b0);
    EndReadout     = 1'b0;
    ReadoutRequest = 1'b0;
    waitCycles(4);

    // Reset in the middle of RECEIVE
    requestFrame();
    waitStart();
    chipWindow(1'b0, 1, 1'b0);
    TransmitOn = 1'b0;
    waitCycles(5);
    chk("busy_mid", ReadoutBusy, 1'b1);
    chk("chips_mid", ChipCount, 4'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_start", StartReadout, 1'b0);
    chk("arst_wen", FifoWriteEn, 1'b0);
    chk("arst_data", FifoData, 16'h0000);
    chk("arst_busy", ReadoutBusy, 1'b0);
    chk("arst_done", ReadoutDone, 1'b0);
    chk("arst_chips", ChipCount, 4'd0);
    chk("arst_timeout", TimeoutError, 1'b0);
    expQ.delete();
    ReadoutRequest = 1'b0;
    TransmitOn     = 1'b1;
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(3);
    runFrame(ASIC_NUM);

    // Second request edge while busy must be ignored
    snap = doneCount;
    requestFrame();
    waitStart();
    chipWindow(1'b0, ASIC_NUM, 1'b0);
    ReadoutRequest = 1'b0;
    waitCycles(3);
    ReadoutRequest = 1'b1;
    waitCycles(3);
    for (int i = 1; i < ASIC_NUM; i++)
      chipWindow(i == ASIC_NUM - 1, ASIC_NUM, 1'b0);
    endFrame(snap, ASIC_NUM, 1'b0);
    waitCycles(20);
    chk("no_retrigger", ReadoutBusy, 1'b0);
    chk("no_retrigger_done", doneCount - snap, 1);
    ReadoutRequest = 1'b0;
    waitCycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
